nios2_avalon_st_adapter_symbol_serializer: RTL and testbench



---
 rtl/nios2_avalon_st_adapter_symbol_serializer_if.sv | 39 +++
 rtl/nios2_avalon_st_adapter_symbol_serializer.sv | 169 ++++++++++++++++
 tb/tb_nios2_avalon_st_adapter_symbol_serializer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_avalon_st_adapter_symbol_serializer_if.sv
// Avalon-ST word-in / symbol-out stream bundle for the symbol serializer.
// slave = serializer view, master = the FIFO side plus the downstream sink.
interface nios2_avalon_st_adapter_symbol_serializer_if #(
  parameter int CHANNEL_WIDTH = 6
);
  logic                       in_ready;
  logic                       in_valid;
  logic [CHANNEL_WIDTH+35:0]  in_data;
  logic                       out_ready;
  logic                       out_valid;
  logic [7:0]                 out_data;
  logic [CHANNEL_WIDTH-1:0]   out_channel;
  logic                       out_startofpacket;
  logic                       out_endofpacket;

  modport slave (
    output in_ready,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_channel,
    output out_startofpacket,
    output out_endofpacket
  );

  modport master (
    input  in_ready,
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_channel,
    input  out_startofpacket,
    input  out_endofpacket
  );
endinterface

// File: rtl/nios2_avalon_st_adapter_symbol_serializer.sv
// Serializes 4-symbol packed FIFO words into a byte-wide Avalon-ST stream.
// Define NIOS2_ST_SERIALIZER_PKT_CHECK_EN to compile in the packet-framing checker.
module nios2_avalon_st_adapter_symbol_serializer #(
  parameter int SYMBOLS       = 4,
  parameter int CHANNEL_WIDTH = 6
) (
  input  logic clk,
  input  logic reset_n,
  nios2_avalon_st_adapter_symbol_serializer_if.slave st,
  output logic protocol_error
);

  localparam int SYM_W   = 8 * SYMBOLS;
  localparam int EMPTY_LSB = SYM_W;
  localparam int CHAN_LSB  = SYM_W + 2;
  localparam int SOP_BIT   = CHAN_LSB + CHANNEL_WIDTH;
  localparam int EOP_BIT   = SOP_BIT + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                   state_r, nxt_state_s;
  logic [SYM_W-1:0]         sym_r, nxt_sym_s;
  logic [1:0]               empty_r, nxt_empty_s;
  logic [CHANNEL_WIDTH-1:0] chan_r, nxt_chan_s;
  logic                     sop_r, nxt_sop_s;
  logic                     eop_r, nxt_eop_s;
  logic [1:0]               idx_r, nxt_idx_s;
  logic                     at_last_r, nxt_last_s;

  logic                     out_valid_r;
  logic [7:0]               out_data_r;
  logic [CHANNEL_WIDTH-1:0] out_channel_r;
  logic                     out_sop_r;
  logic                     out_eop_r;

  logic in_ready_s;
  logic load_s;
  logic xfer_s;

  function automatic logic [1:0] last_index(input logic eop, input logic [1:0] empty);
    if (eop) begin
      last_index = 2'(SYMBOLS - 1) - empty;
    end else begin
      last_index = 2'(SYMBOLS - 1);
    end
  endfunction

  // Symbol 0 sits in the most significant byte.
  function automatic logic [7:0] pick_symbol(input logic [SYM_W-1:0] syms, input logic [1:0] idx);
    case (idx)
      2'd0:    pick_symbol = syms[31:24];
      2'd1:    pick_symbol = syms[23:16];
      2'd2:    pick_symbol = syms[15:8];
      2'd3:    pick_symbol = syms[7:0];
      default: pick_symbol = 8'd0;
    endcase
  endfunction

  // The only input-to-output comb path: retiring word frees the slot this edge.
  assign in_ready_s = (state_r == IDLE) || (st.out_ready && at_last_r);
  assign load_s     = st.in_valid && in_ready_s;
  assign xfer_s     = (state_r == SHIFT) && st.out_ready;

  // Next holding-register contents: load wins over advance, retire drops to IDLE.
  always_comb begin
    nxt_state_s = state_r;
    nxt_sym_s   = sym_r;
    nxt_empty_s = empty_r;
    nxt_chan_s  = chan_r;
    nxt_sop_s   = sop_r;
    nxt_eop_s   = eop_r;
    nxt_idx_s   = idx_r;
    if (load_s) begin
      nxt_state_s = SHIFT;
      nxt_sym_s   = st.in_data[SYM_W-1:0];
      nxt_empty_s = st.in_data[EMPTY_LSB +: 2];
      nxt_chan_s  = st.in_data[CHAN_LSB +: CHANNEL_WIDTH];
      nxt_sop_s   = st.in_data[SOP_BIT];
      nxt_eop_s   = st.in_data[EOP_BIT];
      nxt_idx_s   = 2'd0;
    end else if (xfer_s) begin
      if (at_last_r) begin
        nxt_state_s = IDLE;
      end else begin
        nxt_idx_s = idx_r + 2'd1;
      end
    end else begin
      nxt_state_s = state_r;
    end
    nxt_last_s = (nxt_idx_s == last_index(nxt_eop_s, nxt_empty_s));
  end

  // Serializer FSM, holding register and registered stream outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      sym_r         <= '0;
      empty_r       <= 2'd0;
      chan_r        <= '0;
      sop_r         <= 1'b0;
      eop_r         <= 1'b0;
      idx_r         <= 2'd0;
      at_last_r     <= 1'b0;
      out_valid_r   <= 1'b0;
      out_data_r    <= 8'd0;
      out_channel_r <= '0;
      out_sop_r     <= 1'b0;
      out_eop_r     <= 1'b0;
    end else begin
      state_r       <= nxt_state_s;
      sym_r         <= nxt_sym_s;
      empty_r       <= nxt_empty_s;
      chan_r        <= nxt_chan_s;
      sop_r         <= nxt_sop_s;
      eop_r         <= nxt_eop_s;
      idx_r         <= nxt_idx_s;
      at_last_r     <= nxt_last_s;
      out_valid_r   <= (nxt_state_s == SHIFT);
      out_data_r    <= pick_symbol(nxt_sym_s, nxt_idx_s);
      out_channel_r <= nxt_chan_s;
      out_sop_r     <= nxt_sop_s && (nxt_idx_s == 2'd0);
      out_eop_r     <= nxt_eop_s && nxt_last_s;
    end
  end

  assign st.in_ready          = in_ready_s;
  assign st.out_valid         = out_valid_r;
  assign st.out_data          = out_data_r;
  assign st.out_channel       = out_channel_r;
  assign st.out_startofpacket = out_sop_r;
  assign st.out_endofpacket   = out_eop_r;

`ifdef NIOS2_ST_SERIALIZER_PKT_CHECK_EN
  logic in_pkt_r;
  logic protocol_error_r;
  logic frame_err_s;

  // Framing violations of the word being accepted this edge.
  always_comb begin
    frame_err_s = (st.in_data[SOP_BIT] && in_pkt_r)
               || (!st.in_data[SOP_BIT] && !in_pkt_r)
               || ((st.in_data[EMPTY_LSB +: 2] != 2'd0) && !st.in_data[EOP_BIT]);
  end

  // In-packet tracking; eop takes priority so a sop+eop word leaves us outside.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_pkt_r         <= 1'b0;
      protocol_error_r <= 1'b0;
    end else if (load_s) begin
      protocol_error_r <= frame_err_s;
      if (st.in_data[EOP_BIT]) begin
        in_pkt_r <= 1'b0;
      end else if (st.in_data[SOP_BIT]) begin
        in_pkt_r <= 1'b1;
      end else begin
        in_pkt_r <= in_pkt_r;
      end
    end else begin
      protocol_error_r <= 1'b0;
    end
  end

  assign protocol_error = protocol_error_r;
`else
  assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_nios2_avalon_st_adapter_symbol_serializer.sv
// Bench for the symbol serializer: directed vector table, random backpressure
// against a symbol-queue model, reset mid-word and framing-error pulse.
module tb_nios2_avalon_st_adapter_symbol_serializer;

  logic clk = 1'b0;
  logic reset_n;
  logic protocol_error;

  always #5 clk = ~clk;

  nios2_avalon_st_adapter_symbol_serializer_if bus ();

  nios2_avalon_st_adapter_symbol_serializer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .st             (bus),
    .protocol_error (protocol_error)
  );

`ifdef NIOS2_ST_SERIALIZER_PKT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [5:0] ch;
    logic       sop;
    logic       eop;
  } sym_t;

  sym_t q[$];
  logic in_pkt_m = 1'b0;
  logic err_m    = 1'b0;
  bit   rnd_mode = 1'b0;
  int   next_byte = 0;

  typedef struct {
    logic        iv;
    logic [41:0] idata;
    logic        ordy;
    logic        ev;
    logic [7:0]  ed;
    logic [5:0]  ech;
    logic        esop;
    logic        eeop;
    logic        eir;
  } vec_t;

  vec_t tv[$];

  function automatic logic [41:0] mk(input logic eop, input logic sop, input logic [5:0] ch,
                                     input logic [1:0] empty, input logic [31:0] data);
    mk = {eop, sop, ch, empty, data};
  endfunction

  function automatic vec_t v(input logic iv, input logic [41:0] idata, input logic ordy,
                             input logic ev, input logic [7:0] ed, input logic [5:0] ech,
                             input logic esop, input logic eeop, input logic eir);
    v.iv = iv; v.idata = idata; v.ordy = ordy; v.ev = ev; v.ed = ed;
    v.ech = ech; v.esop = esop; v.eeop = eeop; v.eir = eir;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected state is simply the list of symbols still owed by the held word.
  function automatic bit exp_in_ready();
    exp_in_ready = (q.size() == 0) || (bus.out_ready && q.size() == 1);
  endfunction

  task automatic model_check();
    bit ev;
    ev = (q.size() > 0);
    chk("out_valid", bus.out_valid, ev);
    chk("in_ready", bus.in_ready, exp_in_ready());
    chk("protocol_error", protocol_error, CHK_EN ? err_m : 1'b0);
    if (ev) begin
      chk("out_data", bus.out_data, q[0].data);
      chk("out_channel", bus.out_channel, q[0].ch);
      chk("out_sop", bus.out_startofpacket, q[0].sop);
      chk("out_eop", bus.out_endofpacket, q[0].eop);
      if (rnd_mode && bus.out_ready) begin
        chk("byte_seq", bus.out_data, next_byte[7:0]);
        next_byte++;
      end
    end
  endtask

  task automatic model_update();
    bit ir;
    int n;
    logic [41:0] w;
    sym_t s;
    ir = exp_in_ready();
    if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
    err_m = 1'b0;
    if (bus.in_valid && ir) begin
      w = bus.in_data;
      n = w[41] ? 4 - int'(w[33:32]) : 4;
      for (int i = 0; i < n; i++) begin
        s.data = w[31 - 8*i -: 8];
        s.ch   = w[39:34];
        s.sop  = w[40] && (i == 0);
        s.eop  = w[41] && (i == n - 1);
        q.push_back(s);
      end
      err_m = (w[40] && in_pkt_m) || (!w[40] && !in_pkt_m) || (w[33:32] != 2'd0 && !w[41]);
      if (w[41]) in_pkt_m = 1'b0;
      else if (w[40]) in_pkt_m = 1'b1;
    end
  endtask

  task automatic half_a();
    @(negedge clk);
    model_check();
  endtask

  task automatic half_b();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [41:0] w1, w2, wa, wb, wc, cur;
    int gen_count, gen_byte, pkt_left, words_acc, err_seen, n;
    bit have_word, first, acc, done;
    logic eop, sop;
    logic [1:0] empty;
    logic [31:0] d;

    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    w1 = mk(1'b1, 1'b1, 6'd5, 2'd0, 32'hA1B2C3D4);
    w2 = mk(1'b1, 1'b1, 6'd2, 2'd3, 32'h11223344);
    wa = mk(1'b0, 1'b1, 6'd7, 2'd0, 32'h01020304);
    wb = mk(1'b0, 1'b0, 6'd7, 2'd0, 32'h05060708);
    wc = mk(1'b1, 1'b0, 6'd7, 2'd2, 32'h090A0B0C);
    tv.push_back(v(1'b1, w1,  1'b1, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0, 1'b1));
    tv.push_back(v(1'b0, '0,  1'b1, 1'b1, 8'hA1, 6'd5, 1'b1, 1'b0, 1'b0));
    tv.push_back(v(1'b0, '0,  1'b1, 1'b1, 8'hB2, 6'd5, 1'b0, 1'b0, 1'b0));
    tv.push_back(v(1'b0, '0,  1'b1, 1'b1, 8'hC3, 6'd5, 1'b0, 1'b0, 1'b0));
    tv.push_back(v(1'b0, '0,  1'b1, 1'b1, 8'hD4, 6'd5, 1'b0, 1'b1, 1'b1));
    tv.push_back(v(1'b1, w2,  1'b1, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0, 1'b1));
    tv.push_back(v(1'b0, '0,  1'b1, 1'b1, 8'h11, 6'd2, 1'b1, 1'b1, 1'b1));
    tv.push_back(v(1'b1, wa,  1'b1, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0, 1'b1));
    tv.push_back(v(1'b1, wb,  1'b1, 1'b1, 8'h01, 6'd7, 1'b1, 1'b0, 1'b0));
    tv.push_back(v(1'b1, wb,  1'b1, 1'b1, 8'h02, 6'd7, 1'b0, 1'b0, 1'b0));
    tv.push_back(v(1'b1, wb,  1'b1, 1'b1, 8'h03, 6'd7, 1'b0, 1'b0, 1'b0));
    tv.push_back(v(1'b1, wb,  1'b1, 1'b1, 8'h04, 6'd7, 1'b0, 1'b0, 1'b1));
    tv.push_back(v(1'b1, wc,  1'b1, 1'b1, 8'h05, 6'd7, 1'b0, 1'b0, 1'b0));
    tv.push_back(v(1'b1, wc,  1'b1, 1'b1, 8'h06, 6'd7, 1'b0, 1'b0, 1'b0));
    tv.push_back(v(1'b1, wc,  1'b1, 1'b1, 8'h07, 6'd7, 1'b0, 1'b0, 1'b0));
    tv.push_back(v(1'b1, wc,  1'b1, 1'b1, 8'h08, 6'd7, 1'b0, 1'b0, 1'b1));
    tv.push_back(v(1'b0, '0,  1'b1, 1'b1, 8'h09, 6'd7, 1'b0, 1'b0, 1'b0));
    tv.push_back(v(1'b0, '0,  1'b1, 1'b1, 8'h0A, 6'd7, 1'b0, 1'b1, 1'b1));
    tv.push_back(v(1'b0, '0,  1'b1, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0, 1'b1));

    // Reset state while reset is held.
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_data", bus.out_data, 8'h00);
    chk("rst_out_channel", bus.out_channel, 6'd0);
    chk("rst_out_sop", bus.out_startofpacket, 1'b0);
    chk("rst_out_eop", bus.out_endofpacket, 1'b0);
    chk("rst_protocol_error", protocol_error, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Directed table: single word, empty=3 word, back-to-back three-word packet.
    for (int i = 0; i < tv.size(); i++) begin
      bus.in_valid  = tv[i].iv;
      bus.in_data   = tv[i].idata;
      bus.out_ready = tv[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), bus.out_valid, tv[i].ev);
      chk($sformatf("vec%0d_in_ready", i), bus.in_ready, tv[i].eir);
      if (tv[i].ev) begin
        chk($sformatf("vec%0d_data", i), bus.out_data, tv[i].ed);
        chk($sformatf("vec%0d_channel", i), bus.out_channel, tv[i].ech);
        chk($sformatf("vec%0d_sop", i), bus.out_startofpacket, tv[i].esop);
        chk($sformatf("vec%0d_eop", i), bus.out_endofpacket, tv[i].eeop);
      end
      model_check();
      half_b();
    end

    // Random backpressure over 200 words of incrementing bytes.
    rnd_mode  = 1'b1;
    next_byte = 0;
    gen_byte  = 0;
    gen_count = 0;
    pkt_left  = 0;
    words_acc = 0;
    have_word = 1'b0;
    first     = 1'b0;
    cur       = '0;
    done      = 1'b0;
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      if (!have_word && gen_count < 200 && $urandom_range(0, 3) != 0) begin
        if (pkt_left == 0) begin
          pkt_left = $urandom_range(1, 4);
          first = 1'b1;
        end
        sop   = first;
        eop   = (pkt_left == 1);
        empty = eop ? 2'($urandom_range(0, 3)) : 2'd0;
        n     = 4 - int'(empty);
        d     = 32'hEEEEEEEE;
        for (int k = 0; k < n; k++) d[31 - 8*k -: 8] = 8'(gen_byte + k);
        gen_byte += n;
        cur = mk(eop, sop, 6'($urandom_range(0, 63)), empty, d);
        pkt_left--;
        first = 1'b0;
        gen_count++;
        have_word = 1'b1;
      end
      bus.in_valid  = have_word;
      bus.in_data   = cur;
      bus.out_ready = 1'($urandom_range(0, 1));
      half_a();
      acc = have_word && exp_in_ready();
      half_b();
      if (acc) begin
        have_word = 1'b0;
        words_acc++;
      end
      done = (gen_count == 200) && !have_word && (q.size() == 0);
    end
    chk("rnd_completed", done, 1'b1);
    chk("rnd_words", words_acc, 200);
    chk("rnd_byte_count", next_byte, gen_byte);
    rnd_mode      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset asserted while symbol 2 is on the output.
    bus.in_valid = 1'b1;
    bus.in_data  = mk(1'b1, 1'b1, 6'd1, 2'd0, 32'h20212223);
    half_a(); half_b();
    bus.in_valid = 1'b0;
    half_a(); half_b();
    half_a(); half_b();
    half_a();
    chk("pre_rst_symbol2", bus.out_data, 8'h22);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    q.delete();
    in_pkt_m = 1'b0;
    err_m    = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    half_a(); half_b();
    bus.in_valid = 1'b1;
    bus.in_data  = mk(1'b1, 1'b1, 6'd3, 2'd0, 32'h30313233);
    half_a(); half_b();
    bus.in_valid = 1'b0;
    half_a();
    chk("post_rst_first_symbol", bus.out_data, 8'h30);
    half_b();
    for (int i = 0; i < 4; i++) begin half_a(); half_b(); end

    // sop followed by sop: framing error one cycle after the second accept.
    err_seen = 0;
    wa = mk(1'b0, 1'b1, 6'd4, 2'd0, 32'h40414243);
    wb = mk(1'b1, 1'b1, 6'd4, 2'd0, 32'h50515253);
    words_acc = 0;
    for (int i = 0; i < 14; i++) begin
      bus.in_valid = (words_acc < 2);
      bus.in_data  = (words_acc == 0) ? wa : wb;
      half_a();
      if (protocol_error === 1'b1) err_seen++;
      acc = bus.in_valid && exp_in_ready();
      half_b();
      if (acc) words_acc++;
    end
    chk("sop_sop_words", words_acc, 2);
    chk("sop_sop_error_pulses", err_seen, CHK_EN ? 1 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
